// File: rtl/branch_redirect_ctrl.sv
// Execute-stage branch resolution: redirect target, front-end flushes, wrong-path kill
// and saturating branch statistics for a static predict-not-taken pipeline.
module branch_redirect_ctrl #(
  parameter int XLEN        = 32,
  parameter int CNT_W       = 16,
  parameter int KILL_CYCLES = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ex_valid,
  input  logic             ex_is_branch,
  input  logic             ex_is_jal,
  input  logic             ex_is_jalr,
  input  logic             branch_taken,
  input  logic [XLEN-1:0]  ex_pc,
  input  logic [XLEN-1:0]  ex_imm,
  input  logic [XLEN-1:0]  ex_rs1,
  input  logic             stall,
  output logic             pc_redirect,
  output logic [XLEN-1:0]  pc_target,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic             ex_kill,
  output logic             misalign_exc,
  output logic [CNT_W-1:0] cnt_branch,
  output logic [CNT_W-1:0] cnt_taken,
  output logic [CNT_W-1:0] cnt_redirect
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] REDIRECT = 2'd1;
  localparam logic [1:0] SQUASH   = 2'd2;
  localparam logic [1:0] KILL_INIT = 2'(KILL_CYCLES - 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic en);
    sat_inc = (en && !(&c)) ? c + 1'b1 : c;
  endfunction

  logic [1:0]      state_p1;
  logic [1:0]      kill_cnt_p1;
  logic            is_jalr_p0, is_jal_p0, is_br_p0;
  logic            retire_p0, req_p0, misal_p0, go_p0;
  logic [XLEN-1:0] sum_p0, tgt_p0;

  // Stage p0: decode priority jalr > jal > branch, target and alignment
  assign is_jalr_p0 = ex_is_jalr;
  assign is_jal_p0  = ex_is_jal & ~ex_is_jalr;
  assign is_br_p0   = ex_is_branch & ~ex_is_jal & ~ex_is_jalr;
  assign retire_p0  = (state_p1 == IDLE) & ex_valid & ~stall;
  assign req_p0     = retire_p0 & (is_jalr_p0 | is_jal_p0 | (is_br_p0 & branch_taken));
  assign sum_p0     = (is_jalr_p0 ? ex_rs1 : ex_pc) + ex_imm;
  assign tgt_p0     = is_jalr_p0 ? {sum_p0[XLEN-1:1], 1'b0} : sum_p0;
  assign misal_p0   = tgt_p0[1] | tgt_p0[0];
  assign go_p0      = req_p0 & ~misal_p0;

  // Stage p1: redirect FSM and wrong-path kill window
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_p1    <= IDLE;
      kill_cnt_p1 <= 2'd0;
    end else begin
      case (state_p1)
        IDLE:     if (go_p0) state_p1 <= REDIRECT;
        REDIRECT: begin
          if (KILL_CYCLES > 1) begin
            state_p1    <= SQUASH;
            kill_cnt_p1 <= KILL_INIT;
          end else begin
            state_p1 <= IDLE;
          end
        end
        SQUASH: begin
          kill_cnt_p1 <= kill_cnt_p1 - 2'd1;
          if (kill_cnt_p1 <= 2'd1) state_p1 <= IDLE;
        end
        default:  state_p1 <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_target    <= '0;
      misalign_exc <= 1'b0;
      cnt_branch   <= '0;
      cnt_taken    <= '0;
      cnt_redirect <= '0;
    end else begin
      if (go_p0) pc_target <= tgt_p0;
      misalign_exc <= req_p0 & misal_p0;
      cnt_branch   <= sat_inc(cnt_branch, retire_p0 & is_br_p0);
      cnt_taken    <= sat_inc(cnt_taken, retire_p0 & is_br_p0 & branch_taken);
      cnt_redirect <= sat_inc(cnt_redirect, go_p0);
    end
  end

  // Decoded from state so an asynchronous reset drops them immediately
  assign pc_redirect = (state_p1 == REDIRECT);
  assign flush_ifid  = pc_redirect;
  assign flush_idex  = pc_redirect;
  assign ex_kill     = (state_p1 == REDIRECT) | (state_p1 == SQUASH);

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Scoreboard bench for branch_redirect_ctrl with small counters and a two-cycle kill window.
module tb_branch_redirect_ctrl;
  localparam int XLEN = 32;
  localparam int CW   = 4;
  localparam int KC   = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic            ex_valid, ex_is_branch, ex_is_jal, ex_is_jalr, branch_taken, stall;
  logic [XLEN-1:0] ex_pc, ex_imm, ex_rs1;
  logic            pc_redirect, flush_ifid, flush_idex, ex_kill, misalign_exc;
  logic [XLEN-1:0] pc_target;
  logic [CW-1:0]   cnt_branch, cnt_taken, cnt_redirect;

  branch_redirect_ctrl #(.XLEN(XLEN), .CNT_W(CW), .KILL_CYCLES(KC)) dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_is_branch(ex_is_branch),
    .ex_is_jal(ex_is_jal), .ex_is_jalr(ex_is_jalr), .branch_taken(branch_taken),
    .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_rs1(ex_rs1), .stall(stall),
    .pc_redirect(pc_redirect), .pc_target(pc_target), .flush_ifid(flush_ifid),
    .flush_idex(flush_idex), .ex_kill(ex_kill), .misalign_exc(misalign_exc),
    .cnt_branch(cnt_branch), .cnt_taken(cnt_taken), .cnt_redirect(cnt_redirect)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [XLEN-1:0] tgt;
    bit              mis;
    int              due;
  } exp_t;

  exp_t q[$];
  int   errs = 0;
  int   n_chk = 0;
  int   cyc = 0;
  int   kill_left = 0;
  bit   busy_now = 0;
  int   m_br = 0, m_tk = 0, m_rd = 0;

  task automatic chk(input string tag, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic int sat(input int v);
    return (v >= (1 << CW) - 1) ? (1 << CW) - 1 : v + 1;
  endfunction

  task automatic monitor();
    exp_t e;
    bit exp_redir, exp_mis;
    logic [XLEN-1:0] etgt;
    cyc++;
    exp_redir = 0; exp_mis = 0; etgt = '0;
    if (q.size() > 0 && q[0].due == cyc) begin
      e = q.pop_front();
      exp_redir = !e.mis;
      exp_mis   = e.mis;
      etgt      = e.tgt;
    end
    if (exp_redir) kill_left = KC;
    chk("pc_redirect", 32'(pc_redirect), 32'(exp_redir));
    chk("flush_ifid", 32'(flush_ifid), 32'(exp_redir));
    chk("flush_idex", 32'(flush_idex), 32'(exp_redir));
    chk("misalign_exc", 32'(misalign_exc), 32'(exp_mis));
    if (exp_redir) chk("pc_target", pc_target, etgt);
    busy_now = (kill_left > 0);
    chk("ex_kill", 32'(ex_kill), 32'(busy_now));
    if (kill_left > 0) kill_left--;
    chk("cnt_branch", 32'(cnt_branch), 32'(m_br));
    chk("cnt_taken", 32'(cnt_taken), 32'(m_tk));
    chk("cnt_redirect", 32'(cnt_redirect), 32'(m_rd));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    monitor();
  endtask

  task automatic drive(input bit v, input bit br, input bit jal, input bit jalr, input bit tk,
                       input logic [XLEN-1:0] pc, input logic [XLEN-1:0] imm,
                       input logic [XLEN-1:0] rs1, input bit st);
    exp_t e;
    logic [XLEN-1:0] t;
    bit req;
    ex_valid = v; ex_is_branch = br; ex_is_jal = jal; ex_is_jalr = jalr;
    branch_taken = tk; ex_pc = pc; ex_imm = imm; ex_rs1 = rs1; stall = st;
    if (v && !st && !busy_now) begin
      if (br && !jal && !jalr) begin
        m_br = sat(m_br);
        if (tk) m_tk = sat(m_tk);
      end
      req = jalr || jal || (br && tk);
      if (jalr) t = (rs1 + imm) & ~32'd1;
      else      t = pc + imm;
      if (req) begin
        e.tgt = t;
        e.mis = (t[1:0] != 2'b00);
        e.due = cyc + 1;
        q.push_back(e);
        if (!e.mis) m_rd = sat(m_rd);
      end
    end
    tick();
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, '0, '0, '0, 0);
  endtask

  task automatic drain();
    for (int i = 0; i < 8 && (busy_now || q.size() > 0); i++) idle();
  endtask

  initial begin
    reset = 1'b1;
    ex_valid = 0; ex_is_branch = 0; ex_is_jal = 0; ex_is_jalr = 0;
    branch_taken = 0; stall = 0; ex_pc = '0; ex_imm = '0; ex_rs1 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc_redirect", 32'(pc_redirect), 32'd0);
    chk("rst_ex_kill", 32'(ex_kill), 32'd0);
    chk("rst_misalign", 32'(misalign_exc), 32'd0);
    chk("rst_pc_target", pc_target, 32'd0);
    chk("rst_cnt_branch", 32'(cnt_branch), 32'd0);
    reset = 1'b0;
    idle();

    // beq taken 0x100 + 0x20
    drive(1, 1, 0, 0, 1, 32'h100, 32'h20, '0, 0);
    drain();
    chk("beq_counts", 32'({cnt_branch, cnt_taken, cnt_redirect}), 32'h111);

    // bne not taken
    drive(1, 1, 0, 0, 0, 32'h200, 32'h40, '0, 0);
    idle();
    chk("bne_cnt_taken", 32'(cnt_taken), 32'd1);

    // jalr to 0x1006: misaligned, no redirect
    drive(1, 0, 0, 1, 0, 32'h300, 32'h4, 32'h1003, 0);
    idle();

    // jalr aligned with bit0 dropped, negative immediate
    drive(1, 0, 0, 1, 0, 32'h300, 32'hFFFF_FFFC, 32'h2005, 0);
    drain();

    // misaligned taken branch still counts as branch/taken
    drive(1, 1, 0, 0, 1, 32'h100, 32'h2, '0, 0);
    idle();

    // taken branch, then jal and branch presented during REDIRECT/SQUASH
    drive(1, 1, 0, 0, 1, 32'h400, 32'h80, '0, 0);
    drive(1, 0, 1, 0, 0, 32'h404, 32'h100, '0, 0);
    drive(1, 1, 0, 0, 1, 32'h408, 32'h100, '0, 1);
    drain();

    // stall holds a taken branch for three cycles
    for (int i = 0; i < 3; i++) drive(1, 1, 0, 0, 1, 32'h500, 32'h10, '0, 1);
    drive(1, 1, 0, 0, 1, 32'h500, 32'h10, '0, 0);
    drain();

    // invalid instruction ignored; jal wrap-around target
    drive(0, 0, 1, 0, 0, 32'h600, 32'h8, '0, 0);
    drive(1, 0, 1, 0, 0, 32'hFFFF_FFF0, 32'h20, '0, 0);
    drain();

    // illegal combo: jalr wins over branch
    drive(1, 1, 0, 1, 1, 32'h700, 32'h8, 32'h800, 0);
    drain();

    // saturation with 4-bit counters
    for (int n = 0; n < 20; n++) begin
      drive(1, 1, 0, 0, 1, 32'h1000 + 32'(n * 16), 32'h40, '0, 0);
      drain();
    end
    chk("sat_cnt_taken", 32'(cnt_taken), 32'd15);
    chk("sat_cnt_redirect", 32'(cnt_redirect), 32'd15);

    // async reset in the middle of REDIRECT
    drive(1, 1, 0, 0, 1, 32'h900, 32'h20, '0, 0);
    chk("pre_rst_redirect", 32'(pc_redirect), 32'd1);
    reset = 1'b1;
    #1;
    chk("async_rst_redirect", 32'(pc_redirect), 32'd0);
    chk("async_rst_kill", 32'(ex_kill), 32'd0);
    chk("async_rst_flush", 32'(flush_ifid | flush_idex), 32'd0);
    chk("async_rst_target", pc_target, 32'd0);
    chk("async_rst_cnt", 32'(cnt_taken), 32'd0);
    q.delete();
    kill_left = 0; busy_now = 0; m_br = 0; m_tk = 0; m_rd = 0;
    #2;
    reset = 1'b0;
    idle();
    drive(1, 0, 1, 0, 0, 32'hA00, 32'h10, '0, 0);
    drain();
    chk("queue_empty", 32'(q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, n_chk);
    $finish;
  end
endmodule
